// File: rtl/match_sequence_tx.sv
// TX chip-sequence generator: plays up to 128 QPSK chips from an 8x32 coefficient
// store, highest chip first, one chip per TX sample strobe.
module match_sequence_tx #(
    parameter logic signed [15:0] AMP = 16'sh4000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               txstrobe,
    input  logic [31:0]        cdata,
    input  logic [2:0]         cstate,
    input  logic               cwrite,
    input  logic               start,
    input  logic [7:0]         seq_len,
    input  logic               abort,
    output logic signed [15:0] tx_i,
    output logic signed [15:0] tx_q,
    output logic               sample_valid,
    output logic               busy,
    output logic               done,
    output logic [15:0]        debugbus
);

    localparam logic signed [15:0] NEG_AMP = -AMP;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t             r_state, w_state_n;
    logic [6:0]         r_chip_idx, w_chip_idx_n;
    logic signed [15:0] r_tx_i, r_tx_q, w_tx_i_n, w_tx_q_n;
    logic               r_valid, r_done, w_valid_n, w_done_n;
    logic [31:0]        r_coef [8];

    logic               w_busy;
    logic [6:0]         w_start_idx;
    logic [31:0]        w_word;
    logic               w_re, w_im;
    logic signed [15:0] w_chip_i, w_chip_q;

    assign w_busy = (r_state == S_RUN);

    // Store is deliberately outside the reset domain so contents survive reset.
    always_ff @(posedge clk) begin
        if (cwrite && !w_busy)
            r_coef[cstate] <= cdata;
    end

    assign w_start_idx = (seq_len == 8'd0 || seq_len > 8'd128) ? 7'd127
                                                              : 7'(seq_len - 8'd1);

    // Chip k lives at word k[6:4], real bit 16+k[3:0], imaginary bit k[3:0].
    assign w_word = r_coef[r_chip_idx[6:4]];
    assign w_re   = w_word[{1'b1, r_chip_idx[3:0]}];
    assign w_im   = w_word[{1'b0, r_chip_idx[3:0]}];

    always_comb begin
        w_chip_i = '0;
        w_chip_q = '0;
        case ({w_re, w_im})
            2'b00:   w_chip_i = AMP;
            2'b01:   w_chip_q = NEG_AMP;
            2'b10:   w_chip_q = AMP;
            default: w_chip_i = NEG_AMP;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_chip_idx <= '0;
            r_tx_i     <= '0;
            r_tx_q     <= '0;
            r_valid    <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_n;
            r_chip_idx <= w_chip_idx_n;
            r_tx_i     <= w_tx_i_n;
            r_tx_q     <= w_tx_q_n;
            r_valid    <= w_valid_n;
            r_done     <= w_done_n;
        end
    end

    always_comb begin
        w_state_n    = r_state;
        w_chip_idx_n = r_chip_idx;
        w_tx_i_n     = r_tx_i;
        w_tx_q_n     = r_tx_q;
        w_valid_n    = 1'b0;
        w_done_n     = 1'b0;
        if (abort) begin
            w_state_n    = S_IDLE;
            w_chip_idx_n = '0;
            w_tx_i_n     = '0;
            w_tx_q_n     = '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (txstrobe) begin
                        w_tx_i_n = '0;
                        w_tx_q_n = '0;
                    end
                    if (start) begin
                        w_state_n    = S_RUN;
                        w_chip_idx_n = w_start_idx;
                    end
                end
                S_RUN: begin
                    if (txstrobe) begin
                        w_tx_i_n  = w_chip_i;
                        w_tx_q_n  = w_chip_q;
                        w_valid_n = 1'b1;
                        if (r_chip_idx == 7'd0) begin
                            w_done_n  = 1'b1;
                            w_state_n = S_IDLE;
                        end else begin
                            w_chip_idx_n = r_chip_idx - 7'd1;
                        end
                    end
                end
                default: w_state_n = S_IDLE;
            endcase
        end
    end

    assign tx_i         = r_tx_i;
    assign tx_q         = r_tx_q;
    assign sample_valid = r_valid;
    assign done         = r_done;
    assign busy         = w_busy;
    assign debugbus     = {w_busy, r_done, r_valid, r_state, r_chip_idx, r_tx_i[15:11]};

endmodule

// File: tb/tb_match_sequence_tx.sv
// Randomized bench for match_sequence_tx: a queue-based model of the chip stream
// is compared every cycle, plus directed scenarios with literal expectations.
module tb_match_sequence_tx;

    logic               clk;
    logic               reset;
    logic               txstrobe;
    logic [31:0]        cdata;
    logic [2:0]         cstate;
    logic               cwrite;
    logic               start;
    logic [7:0]         seq_len;
    logic               abort;
    logic signed [15:0] tx_i, tx_q;
    logic               sample_valid, busy, done;
    logic [15:0]        debugbus;

    match_sequence_tx #(.AMP(16'sh4000)) dut (
        .clk(clk), .reset(reset), .txstrobe(txstrobe), .cdata(cdata),
        .cstate(cstate), .cwrite(cwrite), .start(start), .seq_len(seq_len),
        .abort(abort), .tx_i(tx_i), .tx_q(tx_q), .sample_valid(sample_valid),
        .busy(busy), .done(done), .debugbus(debugbus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;

    function automatic void chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endfunction

    function automatic logic [31:0] chip_iq(input logic re, input logic im);
        case ({re, im})
            2'b00:   return {16'h4000, 16'h0000};
            2'b01:   return {16'h0000, 16'hC000};
            2'b10:   return {16'h0000, 16'h4000};
            default: return {16'hC000, 16'h0000};
        endcase
    endfunction

    // Model: at start, the whole expected stream is expanded into a queue.
    logic [31:0] mcoef [8];
    logic [31:0] mq [$];
    logic [31:0] m_pop;
    logic [15:0] m_i = '0, m_q = '0;
    bit          m_busy = 0, m_valid = 0, m_done = 0, m_was_busy = 0;
    int          m_len;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_busy = 0; m_valid = 0; m_done = 0; m_i = '0; m_q = '0;
            mq.delete();
        end else begin
            m_was_busy = m_busy;
            m_valid = 0;
            m_done  = 0;
            if (cwrite && !m_was_busy) mcoef[cstate] = cdata;
            if (abort) begin
                m_busy = 0; m_i = '0; m_q = '0;
                mq.delete();
            end else if (!m_was_busy) begin
                if (txstrobe) begin m_i = '0; m_q = '0; end
                if (start) begin
                    m_len = (seq_len == 0 || seq_len > 128) ? 128 : int'(seq_len);
                    for (int k = m_len - 1; k >= 0; k--)
                        mq.push_back(chip_iq(mcoef[k / 16][16 + k % 16], mcoef[k / 16][k % 16]));
                    m_busy = 1;
                end
            end else if (txstrobe) begin
                m_pop   = mq.pop_front();
                m_i     = m_pop[31:16];
                m_q     = m_pop[15:0];
                m_valid = 1;
                if (mq.size() == 0) begin
                    m_done = 1;
                    m_busy = 0;
                end
            end
        end
    end

    logic [15:0] e_dbg, dbg_mask;
    always @(posedge clk) begin
        #1;
        e_dbg    = {m_busy, m_done, m_valid, m_busy, 7'(m_busy ? mq.size() - 1 : 0), m_i[15:11]};
        dbg_mask = m_busy ? 16'hFFFF : 16'hF01F;
        chk("m_tx_i",  tx_i, m_i);
        chk("m_tx_q",  tx_q, m_q);
        chk("m_valid", {15'd0, sample_valid}, {15'd0, m_valid});
        chk("m_done",  {15'd0, done}, {15'd0, m_done});
        chk("m_busy",  {15'd0, busy}, {15'd0, m_busy});
        chk("m_debug", debugbus & dbg_mask, e_dbg & dbg_mask);
    end

    task automatic tick();
        @(posedge clk);
        #2;
        txstrobe = 0; start = 0; abort = 0; cwrite = 0;
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        cwrite = 1; cstate = a; cdata = d;
        tick();
    endtask

    logic [31:0] w0, e;

    initial begin
        reset = 0; txstrobe = 0; cdata = '0; cstate = '0; cwrite = 0;
        start = 0; seq_len = 8'd1; abort = 0;
        repeat (3) tick();
        chk("rst_tx_i", tx_i, 16'h0000);
        chk("rst_tx_q", tx_q, 16'h0000);
        chk("rst_busy", {15'd0, busy}, 16'd0);
        chk("rst_valid", {15'd0, sample_valid}, 16'd0);
        chk("rst_dbg", debugbus, 16'h0000);
        reset = 1;
        tick();
        for (int w = 0; w < 8; w++) wr(3'(w), $urandom);

        // Reset in the middle of a 128-chip run
        seq_len = 8'd128; start = 1; tick();
        chk("a_busy", {15'd0, busy}, 16'd1);
        repeat (40) begin txstrobe = 1; tick(); end
        reset = 0;
        #1;
        chk("a_rst_i", tx_i, 16'h0000);
        chk("a_rst_q", tx_q, 16'h0000);
        chk("a_rst_busy", {15'd0, busy}, 16'd0);
        chk("a_rst_valid", {15'd0, sample_valid}, 16'd0);
        tick();
        reset = 1;
        repeat (3) begin
            txstrobe = 1; tick();
            chk("a_post_valid", {15'd0, sample_valid}, 16'd0);
            chk("a_post_i", tx_i, 16'h0000);
        end

        // Two-chip sequence
        wr(3'd0, 32'h0001_0002);
        seq_len = 8'd2; start = 1; tick();
        txstrobe = 1; tick();
        chk("b1_i", tx_i, 16'h0000);
        chk("b1_q", tx_q, 16'hC000);
        chk("b1_valid", {15'd0, sample_valid}, 16'd1);
        chk("b1_done", {15'd0, done}, 16'd0);
        txstrobe = 1; tick();
        chk("b2_i", tx_i, 16'h0000);
        chk("b2_q", tx_q, 16'h4000);
        chk("b2_done", {15'd0, done}, 16'd1);
        chk("b2_busy", {15'd0, busy}, 16'd0);
        tick();
        chk("b3_hold_q", tx_q, 16'h4000);
        chk("b3_valid", {15'd0, sample_valid}, 16'd0);

        // start together with an idle strobe
        start = 1; txstrobe = 1; tick();
        chk("s_q", tx_q, 16'h0000);
        chk("s_valid", {15'd0, sample_valid}, 16'd0);
        chk("s_busy", {15'd0, busy}, 16'd1);
        abort = 1; tick();
        chk("s_abort_busy", {15'd0, busy}, 16'd0);

        // All-ones image, seq_len 0 means 128 chips
        for (int w = 0; w < 8; w++) wr(3'(w), 32'hFFFF_FFFF);
        seq_len = 8'd0; start = 1; tick();
        for (int k = 1; k <= 129; k++) begin
            txstrobe = 1; tick();
            if (k <= 128) begin
                chk("c_i", tx_i, 16'hC000);
                chk("c_q", tx_q, 16'h0000);
                chk("c_done", {15'd0, done}, {15'd0, k == 128});
            end else begin
                chk("c_129_i", tx_i, 16'h0000);
                chk("c_129_valid", {15'd0, sample_valid}, 16'd0);
            end
        end

        // L=16, strobe every third cycle, restart and write ignored mid-run
        w0 = $urandom;
        wr(3'd0, w0);
        seq_len = 8'd16; start = 1; tick();
        for (int k = 15; k >= 0; k--) begin
            txstrobe = 1; tick();
            e = chip_iq(w0[16 + k], w0[k]);
            chk("d_i", tx_i, e[31:16]);
            chk("d_q", tx_q, e[15:0]);
            chk("d_done", {15'd0, done}, {15'd0, k == 0});
            if (k == 8) begin
                start = 1; seq_len = 8'd3; cwrite = 1; cstate = 3'd0; cdata = ~w0;
            end
            tick();
            tick();
        end

        // Abort together with the fifth strobe of a 10-chip run
        for (int w = 0; w < 8; w++) wr(3'(w), $urandom);
        seq_len = 8'd10; start = 1; tick();
        repeat (4) begin txstrobe = 1; tick(); end
        txstrobe = 1; abort = 1; tick();
        chk("e_i", tx_i, 16'h0000);
        chk("e_q", tx_q, 16'h0000);
        chk("e_valid", {15'd0, sample_valid}, 16'd0);
        chk("e_busy", {15'd0, busy}, 16'd0);
        chk("e_done", {15'd0, done}, 16'd0);

        // Randomized traffic
        repeat (4000) begin
            txstrobe = ($urandom % 2) == 0;
            start    = ($urandom % 25) == 0;
            abort    = ($urandom % 100) == 0;
            cwrite   = ($urandom % 15) == 0;
            cstate   = 3'($urandom);
            cdata    = $urandom;
            seq_len  = (($urandom % 4) == 0) ? 8'($urandom_range(255)) : 8'($urandom_range(1, 20));
            if ($urandom_range(999) == 0) reset = 0;
            tick();
            reset = 1;
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
